shared_mul_unit: RTL

//  Shared, constant-time, iterative unsigned multiplier. It sits directly downstream of the
//  two-requester round-robin arbiter.
//  - Accepts one operand pair from the requester selected by the arbiter's choice signal.
//  - Drives the arbiter's ready input.
//  - Returns the product to the originating requester with a one-cycle response pulse.
//  - Latency is fixed and independent of operand values (no early termination), so timing leaks no data.

---
 rtl/shared_mul_unit_pkg.sv | 26 ++
 rtl/mul_shift_add_dp.sv | 41 ++++
 rtl/shared_mul_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/shared_mul_unit_pkg.sv
// Shared definitions for the constant-time shared multiplier: state encoding,
// counter sizing and response tags.
package shared_mul_unit_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } mul_state_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);

    localparam logic TAG_REQ1 = 1'b0;
    localparam logic TAG_REQ2 = 1'b1;

    // Counter width needed to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: accumulator, shifting multiplicand and multiplier registers.
// One add-shift step per cycle when 'step' is high; 'load' starts a fresh product.
module mul_shift_add_dp
    import shared_mul_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    // The add is always evaluated and only its selection depends on data,
    // so every step costs the same time regardless of operand values.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (load) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
        end else if (step) begin
            acc_q    <= mplier_q[0] ? (acc_q + mcand_q) : acc_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/shared_mul_unit.sv
// Shared constant-time iterative multiplier behind a two-requester arbiter;
// returns each product to its requester as a one-cycle response pulse.
module shared_mul_unit
    import shared_mul_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid_1,
    input  logic               in_valid_2,
    input  logic               in_choice,
    input  logic [WIDTH-1:0]   in_a_1,
    input  logic [WIDTH-1:0]   in_b_1,
    input  logic [WIDTH-1:0]   in_a_2,
    input  logic [WIDTH-1:0]   in_b_2,
    output logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic               out_resp_valid_1,
    output logic               out_resp_valid_2
);

    localparam int CNT_BITS = cnt_width(WIDTH);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WIDTH);

    mul_state_e          state_q;
    mul_state_e          state_d;
    logic [CNT_BITS-1:0] cnt_q;
    logic                tag_q;
    logic                chosen_valid;
    logic                accept;
    logic                load;
    logic                step;
    logic                enter_done;
    logic [WIDTH-1:0]    sel_a;
    logic [WIDTH-1:0]    sel_b;
    logic [2*WIDTH-1:0]  acc;

    assign chosen_valid = in_choice ? in_valid_2 : in_valid_1;
    assign sel_a        = in_choice ? in_a_2 : in_a_1;
    assign sel_b        = in_choice ? in_b_2 : in_b_1;
    assign out_ready    = (state_q == IDLE);
    assign accept       = out_ready && chosen_valid;
    assign enter_done   = (state_q == BUSY) && (state_d == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // BUSY performs WIDTH steps, then spends one more cycle seeing cnt==WIDTH
    // before handing off to DONE; this keeps the response edge at WIDTH+1.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            tag_q <= TAG_REQ1;
        end else if (load) begin
            cnt_q <= '0;
            tag_q <= in_choice;
        end else if (step) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Result and pulses are registered on DONE entry so they appear exactly in the DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_result       <= '0;
            out_resp_valid_1 <= 1'b0;
            out_resp_valid_2 <= 1'b0;
        end else begin
            out_resp_valid_1 <= enter_done && (tag_q == TAG_REQ1);
            out_resp_valid_2 <= enter_done && (tag_q == TAG_REQ2);
            if (enter_done) begin
                out_result <= acc;
            end
        end
    end

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .a     (sel_a),
        .b     (sel_b),
        .acc   (acc)
    );

endmodule
